// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and helpers for the hazard scoreboard: default geometry,
// writer latency codes and forward-select encodings.
package hazard_scoreboard_pkg;

  localparam int unsigned DEPTH_DEF   = 3;
  localparam int unsigned MAX_LAT_DEF = 2;

  localparam int unsigned LAT_ALU  = 1;
  localparam int unsigned LAT_LOAD = 2;

  // Select value 0 always means "take the operand from the register file".
  localparam int unsigned FWD_SEL_RF = 0;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request and hazard/forward response bundle between the decode logic
// and the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned MAX_LAT = 2,
  parameter int unsigned CNT_W   = 16
);
  import hazard_scoreboard_pkg::*;

  localparam int unsigned LatW = idx_w(MAX_LAT + 1);
  localparam int unsigned SelW = idx_w(DEPTH);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic [LatW-1:0]   id_lat;
  logic              flush;

  logic              pc_write;
  logic              ifid_write;
  logic              bubble;
  logic              stall;
  logic [SelW-1:0]   fwd_rs_sel;
  logic [SelW-1:0]   fwd_rt_sel;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite, id_lat, flush,
    input  pc_write, ifid_write, bubble, stall, fwd_rs_sel, fwd_rt_sel, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_regwrite, id_lat, flush,
    output pc_write, ifid_write, bubble, stall, fwd_rs_sel, fwd_rt_sel, stall_count
  );

endinterface

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest in-flight writer of a source register within a stage
// window [Lo, Hi] and reports its stage index and result latency.
module hazard_scoreboard_match #(
  parameter int unsigned RegAw = 5,
  parameter int unsigned Depth = 3,
  parameter int unsigned LatW  = 2,
  parameter int unsigned IdxW  = 2,
  parameter int unsigned Lo    = 0,
  parameter int unsigned Hi    = 1
) (
  input  logic [RegAw-1:0]            src_i,
  input  logic                        src_used_i,
  input  logic [Depth-1:0]            writer_i,
  input  logic [Depth-1:0][RegAw-1:0] rd_i,
  input  logic [Depth-1:0][LatW-1:0]  lat_i,
  output logic                        hit_o,
  output logic [IdxW-1:0]             idx_o,
  output logic [LatW-1:0]             lat_o
);

  // Walk from oldest to youngest so the youngest match is the last one kept.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    lat_o = '0;
    if (src_used_i && (src_i != '0)) begin
      for (int k = int'(Hi); k >= int'(Lo); k--) begin
        if (writer_i[k] && (rd_i[k] == src_i)) begin
          hit_o = 1'b1;
          idx_o = IdxW'(unsigned'(k));
          lat_o = lat_i[k];
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Latency-aware register hazard scoreboard: tracks in-flight writers from EX to
// WB, stalls ID on unresolved dependences and selects EX operand bypasses.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned MAX_LAT = MAX_LAT_DEF,
  parameter int unsigned FWD_EN  = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  hazard_scoreboard_if.slave bus
);

  localparam int unsigned LatW = idx_w(MAX_LAT + 1);
  localparam int unsigned SelW = idx_w(DEPTH);
  localparam logic [LatW-1:0] MaxLat = LatW'(MAX_LAT);

  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0]             we_q, we_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0][LatW-1:0]   lat_q, lat_d;
  logic [REG_AW-1:0]            ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic                         ex_rs_use_q, ex_rs_use_d, ex_rt_use_q, ex_rt_use_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [DEPTH-1:0] writer;
  logic             lat_ok;
  logic [LatW-1:0]  lat_eff;
  logic             rs_haz, rt_haz, stall, issue;

  logic            id_rs_hit, id_rt_hit, ex_rs_hit, ex_rt_hit;
  logic [SelW-1:0] id_rs_idx, id_rt_idx, ex_rs_idx, ex_rt_idx;
  logic [LatW-1:0] id_rs_lat, id_rt_lat, ex_rs_lat, ex_rt_lat;

  // r0 is hard-wired, so an entry writing it is never a producer.
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      writer[k] = vld_q[k] & we_q[k] & (rd_q[k] != '0);
    end
  end

  hazard_scoreboard_match #(
    .RegAw (REG_AW), .Depth (DEPTH), .LatW (LatW), .IdxW (SelW), .Lo (0), .Hi (DEPTH - 2)
  ) u_id_rs (
    .src_i      (bus.id_rs),
    .src_used_i (bus.id_uses_rs),
    .writer_i   (writer),
    .rd_i       (rd_q),
    .lat_i      (lat_q),
    .hit_o      (id_rs_hit),
    .idx_o      (id_rs_idx),
    .lat_o      (id_rs_lat)
  );

  hazard_scoreboard_match #(
    .RegAw (REG_AW), .Depth (DEPTH), .LatW (LatW), .IdxW (SelW), .Lo (0), .Hi (DEPTH - 2)
  ) u_id_rt (
    .src_i      (bus.id_rt),
    .src_used_i (bus.id_uses_rt),
    .writer_i   (writer),
    .rd_i       (rd_q),
    .lat_i      (lat_q),
    .hit_o      (id_rt_hit),
    .idx_o      (id_rt_idx),
    .lat_o      (id_rt_lat)
  );

  hazard_scoreboard_match #(
    .RegAw (REG_AW), .Depth (DEPTH), .LatW (LatW), .IdxW (SelW), .Lo (1), .Hi (DEPTH - 1)
  ) u_ex_rs (
    .src_i      (ex_rs_q),
    .src_used_i (ex_rs_use_q),
    .writer_i   (writer),
    .rd_i       (rd_q),
    .lat_i      (lat_q),
    .hit_o      (ex_rs_hit),
    .idx_o      (ex_rs_idx),
    .lat_o      (ex_rs_lat)
  );

  hazard_scoreboard_match #(
    .RegAw (REG_AW), .Depth (DEPTH), .LatW (LatW), .IdxW (SelW), .Lo (1), .Hi (DEPTH - 1)
  ) u_ex_rt (
    .src_i      (ex_rt_q),
    .src_used_i (ex_rt_use_q),
    .writer_i   (writer),
    .rd_i       (rd_q),
    .lat_i      (lat_q),
    .hit_o      (ex_rt_hit),
    .idx_o      (ex_rt_idx),
    .lat_o      (ex_rt_lat)
  );

  // A writer at pipe[j] can be bypassed one cycle later from pipe[j+1]; without
  // a bypass network only the register file (written during WB) is usable.
  always_comb begin
    if (FWD_EN != 0) begin
      rs_haz = id_rs_hit && ((int'(id_rs_idx) + 1) < int'(id_rs_lat));
      rt_haz = id_rt_hit && ((int'(id_rt_idx) + 1) < int'(id_rt_lat));
    end else begin
      rs_haz = id_rs_hit;
      rt_haz = id_rt_hit;
    end
    stall = bus.id_valid & ~bus.flush & (rs_haz | rt_haz);
    issue = bus.id_valid & ~stall & ~bus.flush;
  end

  always_comb begin
    bus.stall       = stall;
    bus.bubble      = stall | bus.flush;
    bus.pc_write    = ~stall;
    bus.ifid_write  = ~stall;
    bus.fwd_rs_sel  = (FWD_EN != 0) ? ex_rs_idx : SelW'(FWD_SEL_RF);
    bus.fwd_rt_sel  = (FWD_EN != 0) ? ex_rt_idx : SelW'(FWD_SEL_RF);
    bus.stall_count = cnt_q;
  end

  assign lat_ok  = (bus.id_lat != '0) && (bus.id_lat <= MaxLat);
  assign lat_eff = lat_ok ? bus.id_lat : MaxLat;

  always_comb begin
    vld_d       = {vld_q[DEPTH-2:0], issue};
    we_d        = {we_q[DEPTH-2:0], bus.id_regwrite};
    rd_d        = {rd_q[DEPTH-2:0], bus.id_rd};
    lat_d       = {lat_q[DEPTH-2:0], lat_eff};
    ex_rs_d     = issue ? bus.id_rs : ex_rs_q;
    ex_rt_d     = issue ? bus.id_rt : ex_rt_q;
    ex_rs_use_d = issue & bus.id_uses_rs;
    ex_rt_use_d = issue & bus.id_uses_rt;
    cnt_d       = (stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q       <= '0;
      we_q        <= '0;
      rd_q        <= '0;
      lat_q       <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_rs_use_q <= 1'b0;
      ex_rt_use_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      vld_q       <= vld_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      lat_q       <= lat_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_rs_use_q <= ex_rs_use_d;
      ex_rt_use_q <= ex_rt_use_d;
      cnt_q       <= cnt_d;
    end
  end

  // Bypassing from a stage whose result is not ready yet means a missed stall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (issue && bus.id_regwrite) assert (lat_ok);
      if (ex_rs_hit) assert (ex_rs_idx >= SelW'(ex_rs_lat));
      if (ex_rt_hit) assert (ex_rt_idx >= SelW'(ex_rt_lat));
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against
// an age-based model of in-flight writers, with and without forwarding.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int Depth = 3;

  typedef struct {
    bit v; int rd; int rs; int rt; bit urs; bit urt; bit rw; int lat; bit fl;
  } ins_t;
  typedef struct { int rd; int lat; longint cyc; } wr_t;

  logic clock = 1'b0;
  logic rst = 1'b1;
  logic rst_sat = 1'b1;
  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .MAX_LAT(2), .CNT_W(16)) bus1 ();
  hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .MAX_LAT(2), .CNT_W(16)) bus0 ();
  hazard_scoreboard_if #(.REG_AW(5), .DEPTH(16), .MAX_LAT(2), .CNT_W(16)) bus_s ();

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .MAX_LAT(2), .FWD_EN(1), .CNT_W(16)) u_fwd (
    .clock (clock), .reset (rst), .bus (bus1.slave)
  );
  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .MAX_LAT(2), .FWD_EN(0), .CNT_W(16)) u_nofwd (
    .clock (clock), .reset (rst), .bus (bus0.slave)
  );
  hazard_scoreboard #(.REG_AW(5), .DEPTH(16), .MAX_LAT(2), .FWD_EN(0), .CNT_W(16)) u_sat (
    .clock (clock), .reset (rst_sat), .bus (bus_s.slave)
  );

  // Model state, index 1 = forwarding DUT, index 0 = no-forwarding DUT.
  wr_t    q[2][$];
  ins_t   cur;
  ins_t   ex[2];
  bit     exv[2];
  int     cnt[2];
  bit     s[2];
  longint now;
  longint sat_start;
  int     n_assert;
  int     n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Youngest writer of src that ID may depend on; age 0 = EX.
  function automatic bit haz(input wr_t wq[$], input int src, input bit used, input bit fwd);
    int age;
    if (!used || src == 0) return 1'b0;
    foreach (wq[i]) begin
      age = int'(now - wq[i].cyc);
      if (age <= Depth - 2 && wq[i].rd == src) return fwd ? (age + 1 < wq[i].lat) : 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int fsel(input wr_t wq[$], input int src, input bit used, input bit fwd);
    int age;
    if (!fwd || !used || src == 0) return 0;
    foreach (wq[i]) begin
      age = int'(now - wq[i].cyc);
      if (age >= 1 && age <= Depth - 1 && wq[i].rd == src) return age;
    end
    return 0;
  endfunction

  function automatic ins_t op(int rd, int rs, int rt, bit urs, bit urt, int lat);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.rw = 1'b1; i.lat = lat; i.fl = 1'b0;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i = '{default: 0};
    return i;
  endfunction

  task automatic drive(input ins_t i);
    cur = i;
    bus1.id_valid = i.v;      bus0.id_valid = i.v;
    bus1.id_rd = 5'(i.rd);    bus0.id_rd = 5'(i.rd);
    bus1.id_rs = 5'(i.rs);    bus0.id_rs = 5'(i.rs);
    bus1.id_rt = 5'(i.rt);    bus0.id_rt = 5'(i.rt);
    bus1.id_uses_rs = i.urs;  bus0.id_uses_rs = i.urs;
    bus1.id_uses_rt = i.urt;  bus0.id_uses_rt = i.urt;
    bus1.id_regwrite = i.rw;  bus0.id_regwrite = i.rw;
    bus1.id_lat = 2'(i.lat);  bus0.id_lat = 2'(i.lat);
    bus1.flush = i.fl;        bus0.flush = i.fl;
  endtask

  task automatic sample();
    bit fwd;
    @(negedge clock);
    for (int m = 0; m < 2; m++) begin
      fwd = (m == 1);
      s[m] = cur.v && !cur.fl &&
             (haz(q[m], cur.rs, cur.urs, fwd) || haz(q[m], cur.rt, cur.urt, fwd));
      chk($sformatf("stall%0d", m), m ? bus1.stall : bus0.stall, 32'(s[m]));
      chk($sformatf("bubble%0d", m), m ? bus1.bubble : bus0.bubble, 32'(s[m] | cur.fl));
      chk($sformatf("pc_write%0d", m), m ? bus1.pc_write : bus0.pc_write, 32'(!s[m]));
      chk($sformatf("ifid_write%0d", m), m ? bus1.ifid_write : bus0.ifid_write, 32'(!s[m]));
      chk($sformatf("stall_count%0d", m), m ? bus1.stall_count : bus0.stall_count,
          32'(cnt[m]));
      if (exv[m]) begin
        chk($sformatf("fwd_rs%0d", m), m ? bus1.fwd_rs_sel : bus0.fwd_rs_sel,
            32'(fsel(q[m], ex[m].rs, ex[m].urs, fwd)));
        chk($sformatf("fwd_rt%0d", m), m ? bus1.fwd_rt_sel : bus0.fwd_rt_sel,
            32'(fsel(q[m], ex[m].rt, ex[m].urt, fwd)));
      end
    end
  endtask

  task automatic adv();
    bit iss;
    @(posedge clock);
    now++;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        q[m].delete();
        exv[m] = 1'b0;
        cnt[m] = 0;
      end else begin
        iss = cur.v && !cur.fl && !s[m];
        if (s[m] && cnt[m] < 32'hFFFF) cnt[m]++;
        if (iss && cur.rw && cur.rd != 0) q[m].push_front('{rd: cur.rd, lat: cur.lat, cyc: now});
        ex[m] = cur;
        exv[m] = iss;
        while (q[m].size() > 0 && now - q[m][$].cyc >= Depth) void'(q[m].pop_back());
      end
    end
    #1;
  endtask

  task automatic cyc_run();
    sample();
    adv();
  endtask

  task automatic idle(input int n);
    drive(nop());
    repeat (n) cyc_run();
  endtask

  initial begin
    ins_t r;
    n_assert = 0; n_fail = 0; now = 0;
    for (int m = 0; m < 2; m++) begin exv[m] = 1'b0; cnt[m] = 0; s[m] = 1'b0; end
    // Saturation DUT: a self-dependent writer in ID keeps it stalled 15 of every 16 cycles.
    bus_s.id_valid = 1'b1; bus_s.id_rs = 5'd1; bus_s.id_rt = 5'd0;
    bus_s.id_uses_rs = 1'b1; bus_s.id_uses_rt = 1'b0; bus_s.id_rd = 5'd1;
    bus_s.id_regwrite = 1'b1; bus_s.id_lat = 2'(LAT_ALU); bus_s.flush = 1'b0;
    drive(nop());
    repeat (2) adv();
    rst = 1'b0; rst_sat = 1'b0; sat_start = now;

    // Reset state
    sample();
    chk("rst_stall", bus1.stall, 0);
    chk("rst_bubble", bus1.bubble, 0);
    chk("rst_pcw", bus1.pc_write, 1);
    chk("rst_frs", bus1.fwd_rs_sel, 0);
    chk("rst_frt", bus1.fwd_rt_sel, 0);
    chk("rst_cnt", bus1.stall_count, 0);
    chk("rst_sat_cnt", bus_s.stall_count, 0);
    adv();

    // ALU to ALU back-to-back: bypass from pipe[1]
    drive(op(3, 1, 2, 1, 1, LAT_ALU)); cyc_run();
    drive(op(4, 3, 1, 1, 1, LAT_ALU)); sample(); chk("t1_stall", bus1.stall, 0); adv();
    drive(nop()); sample();
    chk("t1_frs", bus1.fwd_rs_sel, 1); chk("t1_frt", bus1.fwd_rt_sel, 0); adv();

    // Load-use: one stall cycle, then bypass from pipe[2]
    idle(3);
    drive(op(5, 1, 0, 1, 0, LAT_LOAD)); cyc_run();
    drive(op(6, 5, 5, 1, 1, LAT_ALU)); sample();
    chk("t2_stall", bus1.stall, 1); chk("t2_pcw", bus1.pc_write, 0);
    chk("t2_ifid", bus1.ifid_write, 0); chk("t2_bubble", bus1.bubble, 1); adv();
    sample(); chk("t2_stall_gone", bus1.stall, 0); adv();
    drive(nop()); sample();
    chk("t2_frs", bus1.fwd_rs_sel, 2); chk("t2_frt", bus1.fwd_rt_sel, 2);
    chk("t2_cnt", bus1.stall_count, 1); adv();

    // Load, independent op, then use
    idle(3);
    drive(op(5, 1, 0, 1, 0, LAT_LOAD)); cyc_run();
    drive(op(7, 1, 2, 1, 1, LAT_ALU)); cyc_run();
    drive(op(8, 5, 0, 1, 0, LAT_ALU)); sample(); chk("t3_stall", bus1.stall, 0); adv();
    drive(nop()); sample(); chk("t3_frs", bus1.fwd_rs_sel, 2); adv();

    // Youngest writer wins; r0 never hazards or forwards
    idle(3);
    drive(op(4, 1, 2, 1, 1, LAT_ALU)); cyc_run();
    drive(op(4, 2, 1, 1, 1, LAT_ALU)); cyc_run();
    drive(op(9, 4, 0, 1, 0, LAT_ALU)); cyc_run();
    drive(nop()); sample(); chk("t4_frs", bus1.fwd_rs_sel, 1); adv();
    drive(op(0, 1, 2, 1, 1, LAT_LOAD)); cyc_run();
    drive(op(10, 0, 0, 1, 1, LAT_ALU)); sample(); chk("t4_r0_stall", bus1.stall, 0); adv();
    drive(nop()); sample();
    chk("t4_r0_frs", bus1.fwd_rs_sel, 0); chk("t4_r0_frt", bus1.fwd_rt_sel, 0); adv();

    // Flush beats stall, and the flushed instruction never enters the pipe
    idle(3);
    drive(op(5, 1, 0, 1, 0, LAT_LOAD)); cyc_run();
    r = op(6, 5, 5, 1, 1, LAT_ALU); r.fl = 1'b1;
    drive(r); sample();
    chk("t5_fl_stall", bus1.stall, 0); chk("t5_fl_bubble", bus1.bubble, 1); adv();
    drive(op(11, 6, 0, 1, 0, LAT_ALU)); cyc_run();
    drive(nop()); sample(); chk("t5_fl_frs", bus1.fwd_rs_sel, 0); adv();

    // Reset in the middle of a load-use stall
    idle(3);
    drive(op(5, 1, 0, 1, 0, LAT_LOAD)); cyc_run();
    drive(op(6, 5, 5, 1, 1, LAT_ALU)); sample(); chk("t5_pre_rst_stall", bus1.stall, 1);
    rst = 1'b1; adv(); rst = 1'b0;
    sample(); chk("t5_post_rst_stall", bus1.stall, 0);
    chk("t5_post_rst_cnt", bus1.stall_count, 0); adv();
    drive(nop()); sample();
    chk("t5_post_rst_frs", bus1.fwd_rs_sel, 0); chk("t5_post_rst_frt", bus1.fwd_rt_sel, 0); adv();

    // No bypass network: wait until the writer reaches WB
    idle(3);
    drive(op(3, 1, 2, 1, 1, LAT_ALU)); sample(); chk("t6_stall_a", bus0.stall, 0); adv();
    drive(op(4, 3, 0, 1, 0, LAT_ALU));
    sample(); chk("t6_stall_b", bus0.stall, 1); adv();
    sample(); chk("t6_stall_c", bus0.stall, 1); adv();
    sample(); chk("t6_stall_d", bus0.stall, 0); adv();
    drive(nop()); sample(); chk("t6_frs", bus0.fwd_rs_sel, 0); adv();

    // Random traffic; a stalled ID instruction usually holds
    for (int n = 0; n < 3000; n++) begin
      if (!s[1] || $urandom_range(0, 3) == 0) begin
        r.v   = ($urandom_range(0, 9) != 0);
        r.rd  = int'($urandom_range(0, 7));
        r.rs  = int'($urandom_range(0, 7));
        r.rt  = int'($urandom_range(0, 7));
        r.urs = ($urandom_range(0, 4) != 0);
        r.urt = ($urandom_range(0, 2) != 0);
        r.rw  = ($urandom_range(0, 3) != 0);
        r.lat = int'($urandom_range(LAT_ALU, LAT_LOAD));
        r.fl  = ($urandom_range(0, 9) == 0);
        drive(r);
      end
      cyc_run();
    end

    // Saturating stall counter
    drive(nop());
    while (now - sat_start < 70000) cyc_run();
    chk("sat_cnt", bus_s.stall_count, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed forwarding and load-use hazard logic of the 5-stage MIPS pipeline.
- Tracks in-flight register writers in a DEPTH-entry shift register, one entry per stage from EX onward.
- Each writer carries its own result latency, so multi-cycle results are handled as well as 1-cycle ALU and 2-cycle loads.
- Sits between ID and EX; drives PC/IFID write enables, ID/EX bubble insertion and EX operand-forward selects.

Parameters:
- REG_AW, 5, register index width
- DEPTH, 3, tracked stages EX..WB; pipe[0]=EX, pipe[DEPTH-1]=WB
- MAX_LAT, 2, maximum writer latency in stages; must be ≤ DEPTH-1
- FWD_EN, 1, 1=bypass network present; 0=no forwarding, stall until result is in WB
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_rd  in  REG_AW  ID destination
- id_regwrite  in  1  ID instruction writes id_rd
- id_lat  in  clog2(MAX_LAT+1)  stages after EX entry until result is forwardable (ALU=1, LW=2)
- flush  in  1  squash the ID instruction (branch taken)
- pc_write, ifid_write  out  1  ~stall
- bubble  out  1  force ID/EX controls to NOP
- stall  out  1  hazard detected this cycle
- fwd_rs_sel, fwd_rt_sel  out  clog2(DEPTH)  EX operand source: 0=register file, k=pipe[k]
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Entry fields: valid, rd, lat. An entry counts as a writer only if valid, regwrite and rd≠0; r0 never hazards or forwards.
- Every cycle pipe[k+1]←pipe[k] and pipe[DEPTH-1] retires.
- pipe[0] loads the ID instruction when issue = id_valid & ~stall & ~flush; otherwise it loads a bubble (valid=0).
- On issue, the ID sources are also registered as ex_rs/ex_rt with their use bits.
- Stall (FWD_EN=1), evaluated per used nonzero source:
  - Find the youngest (lowest j) writer pipe[j], j∈0..DEPTH-2, with rd equal to the source.
  - Hazard if j+1 < pipe[j].lat.
  - Older matches are ignored once a younger match is found.
- Stall (FWD_EN=0): hazard if any writer in pipe[0..DEPTH-2] matches. Register file writes in the first half-cycle, so WB needs no stall.
- stall = id_valid & ~flush & (rs hazard | rt hazard). Combinational, same cycle.
- bubble = stall | flush.
- Forward selects (combinational from the registered ex_rs/ex_rt):
  - Select the youngest writer among pipe[1..DEPTH-1] with matching rd; else 0.
  - Forced to 0 when FWD_EN=0, the source is unused, or the source is r0.
- Stall guarantees that any selected pipe[k] has k ≥ lat.
- stall_count increments on each stall cycle and saturates at all-ones.
- Simultaneous events:
  - flush beats stall: stall=0, bubble=1.
  - A stalled ID instruction re-evaluates each cycle until its writer advances.
- Reset (synchronous, any time including mid-stall):
  - All valid bits, ex_rs/ex_rt and use bits and stall_count clear.
  - Next cycle: stall=0, bubble=0, pc_write=ifid_write=1, fwd selects=0.
- Out-of-range id_lat (0 or >MAX_LAT) is treated as MAX_LAT; assertion in simulation.

Decomposition:
- Shared constants in constants.h: DEPTH, MAX_LAT, latency codes LAT_ALU=1, LAT_LOAD=2, forward-select encodings.
- One natural sub-module, scoreboard_match: given a source index and the pipe entries, returns youngest hit, its index and its lat. Instantiated four times: 2× ID stall check, 2× EX forward select.

Test Plan (DEPTH=3, MAX_LAT=2, FWD_EN=1 unless noted):
1. add r3 ← r1,r2 then add r4 ← r3,r1 back-to-back -> no stall; in the consumer's EX cycle fwd_rs_sel=1, fwd_rt_sel=0.
2. lw r5 (lat 2) then add r6 ← r5,r5 -> stall=1, pc_write=ifid_write=0, bubble=1 for exactly 1 cycle; then fwd_rs_sel=fwd_rt_sel=2; stall_count=1.
3. lw r5, independent instruction, then use r5 -> no stall, fwd_rs_sel=2.
4. add r4, sub r4, then use r4 -> fwd_rs_sel=1 (youngest wins). Also: write r0 then use r0 -> no stall, sel 0.
5. lw r5 followed by a dependent instruction with flush asserted in the same cycle -> stall=0, bubble=1, and no entry issued. Reset asserted mid-stall -> stall=0 the next cycle with all entries invalid.
6. FWD_EN=0: add r3 then use r3 -> stall for 2 cycles, fwd selects stay 0; 65 536+ stall cycles -> stall_count holds 0xFFFF.
